// File: rtl/cia_timer_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module  : cia_timer_ctrl_if
// Purpose : Control-register bus between the CIA register decoder and a timer.
// Revision: 1.0  initial release
// =============================================================================
interface cia_timer_ctrl_if;
    logic       cr_wr;
    logic [7:0] cr_wdata;
    logic [7:0] cr_rdata;

    modport master (
        output cr_wr,
        output cr_wdata,
        input  cr_rdata
    );

    modport slave (
        input  cr_wr,
        input  cr_wdata,
        output cr_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cia_timer_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : cia_timer_ctrl
// Purpose : CIA interval-timer control register, tick qualification, underflow,
//           reload, one-shot stop, PB output and interrupt-set generation.
// Revision: 1.0  initial release
// =============================================================================
module cia_timer_ctrl #(
    parameter bit TIMER_B = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            phi2_en,
    input  logic            cnt_edge,
    input  logic            cnt_level,
    input  logic            ta_uf,
    cia_timer_ctrl_if.slave cr_bus,
    input  logic            tmr_zero,
    output logic            tmr_tick,
    output logic            tmr_load,
    output logic            uf_pulse,
    output logic            irq_set,
    output logic            pb_out,
    output logic            pb_oe
);

    localparam int START_BIT   = 0;
    localparam int PBON_BIT    = 1;
    localparam int OUTMODE_BIT = 2;
    localparam int RUNMODE_BIT = 3;
    localparam int LOAD_BIT    = 4;

    logic [7:0] cr_q, cr_d;
    logic       load_pend_q, load_pend_d;
    logic       toggle_q, toggle_d;
    logic       pulse_q, pulse_d;
    logic       irq_q, irq_d;
    logic       src_evt;
    logic       uf;
    logic       start_rise;

    generate
        if (TIMER_B) begin : g_timer_b
            assign src_evt = (cr_q[6:5] == 2'b00) ? phi2_en  :
                             (cr_q[6:5] == 2'b01) ? cnt_edge :
                             (cr_q[6:5] == 2'b10) ? ta_uf    :
                                                    (ta_uf & cnt_level);
        end else begin : g_timer_a
            // Cascade inputs have no meaning for Timer A.
            logic unused_cascade;
            assign unused_cascade = ta_uf ^ cnt_level;
            assign src_evt = cr_q[5] ? cnt_edge : phi2_en;
        end
    endgenerate

    assign tmr_tick   = cr_q[START_BIT] & src_evt & ~load_pend_q;
    assign uf         = tmr_tick & tmr_zero;
    assign uf_pulse   = uf;
    assign tmr_load   = uf | load_pend_q;
    assign irq_set    = irq_q;
    assign pb_oe      = cr_q[PBON_BIT];
    assign pb_out     = cr_q[OUTMODE_BIT] ? toggle_q : pulse_q;
    assign cr_bus.cr_rdata = cr_q;
    assign start_rise = cr_bus.cr_wr & cr_bus.cr_wdata[START_BIT] & ~cr_q[START_BIT];

    always_comb begin
        cr_d        = cr_q;
        load_pend_d = 1'b0;
        toggle_d    = toggle_q;
        pulse_d     = pulse_q;
        irq_d       = uf;

        // A write always wins, so a START write overrides the one-shot stop.
        if (cr_bus.cr_wr) begin
            cr_d           = cr_bus.cr_wdata;
            cr_d[LOAD_BIT] = 1'b0;
            load_pend_d    = cr_bus.cr_wdata[LOAD_BIT];
        end else if (uf && cr_q[RUNMODE_BIT]) begin
            cr_d[START_BIT] = 1'b0;
        end

        if (uf) begin
            pulse_d = 1'b1;
        end else if (phi2_en) begin
            pulse_d = 1'b0;
        end

        if (start_rise) begin
            toggle_d = 1'b1;
        end else if (uf) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_q        <= 8'h00;
            load_pend_q <= 1'b0;
            toggle_q    <= 1'b0;
            pulse_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            cr_q        <= cr_d;
            load_pend_q <= load_pend_d;
            toggle_q    <= toggle_d;
            pulse_q     <= pulse_d;
            irq_q       <= irq_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/cia_timer_ctrl.md
# cia_timer_ctrl

Control-register and sequencing logic for one CIA interval timer (Timer A or Timer B). It holds the timer's control register (CRA/CRB) and qualifies the count source into one-cycle decrement ticks. It detects underflow, drives force-load and auto-reload, and handles one-shot stop. It also generates the PB6/PB7 timer output and the interrupt-set pulse. It sits between the CIA register decoder and the 16-bit down-counter datapath; a Timer B instance cascades from Timer A's `uf_pulse`.

## Interface
- `TIMER_B`, default 0: 0 = Timer A control semantics; 1 = Timer B (2-bit input-mode field, cascade sources enabled).
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `phi2_en` in 1: one-cycle pulse per phi2 cycle; count source in phi2 mode and timebase for pulse-mode PB.
- `cnt_edge` in 1: synchronized rising edge of the CNT pin; one-cycle pulse.
- `cnt_level` in 1: synchronized CNT pin level.
- `ta_uf` in 1: Timer A underflow pulse; used only when `TIMER_B`=1.
- `cr_wr` in 1: control-register write strobe.
- `cr_wdata` in 8: control-register write data.
- `cr_rdata` out 8: control-register readback.
- `tmr_zero` in 1: datapath counter == 0.
- `tmr_tick` out 1: decrement request to datapath.
- `tmr_load` out 1: load latch value into counter.
- `uf_pulse` out 1: underflow event; combinational, same cycle as tick.
- `irq_set` out 1: one-cycle pulse to ICR flag logic.
- `pb_out` out 1: timer output bit (PB6 for A, PB7 for B).
- `pb_oe` out 1: PB output override enable.

## Operation
- **Control register bits:**
  - bit0 START
  - bit1 PBON
  - bit2 OUTMODE (0 pulse, 1 toggle)
  - bit3 RUNMODE (0 continuous, 1 one-shot)
  - bit4 LOAD (strobe; not stored; reads 0)
  - bits7:5 stored and read back only, except the input-mode bits below.
- **Input mode, `TIMER_B`=0:** bit5 selects source: 0 = `phi2_en`, 1 = `cnt_edge`.
- **Input mode, `TIMER_B`=1:** bits6:5 select source:
  - 00 = `phi2_en`
  - 01 = `cnt_edge`
  - 10 = `ta_uf`
  - 11 = `ta_uf & cnt_level`
- **Tick:** `src_evt` = selected source. `tmr_tick` = START & `src_evt` & ~`load_pend` (combinational).
- **Underflow:** `uf` = `tmr_tick` & `tmr_zero`.
  - `uf_pulse` = `uf`.
  - `tmr_load` = `uf` | `load_pend`; reload occurs in the same cycle as underflow, in both run modes.
- **One-shot:** on `uf` with RUNMODE=1, START clears on the next edge.
- **Force load:** a write with bit4=1 sets `load_pend` for exactly the next cycle. In that cycle `tmr_load`=1 and the tick is suppressed. Force load is legal with START=0.
- **PB pulse mode:**
  - `pb_out` goes 1 on the edge after `uf`.
  - It returns to 0 on the edge after the next `phi2_en`.
- **PB toggle mode:**
  - The toggle flip-flop inverts on the edge after each `uf`.
  - It is set to 1 by any write that changes START from 0 to 1.
  - `pb_out` = toggle flip-flop.
- `pb_oe` = PBON.
- **Simultaneous events:**
  - `cr_wr` and `uf` in the same cycle: `uf` is evaluated with the old register, then the written value is stored. A write setting START overrides a one-shot clear in that cycle.
  - A new LOAD write while `load_pend`=1 simply re-arms it for one more cycle.
- **Reset (`rst_n`=0, asynchronous):**
  - Register = 0x00, `load_pend` = 0, toggle flip-flop = 0, pulse flip-flop = 0.
  - Consequently `cr_rdata`=0x00 and `pb_out`, `pb_oe`, `irq_set`, `tmr_tick`, `tmr_load`, `uf_pulse` all = 0.
  - Reset mid-count stops ticking immediately; counter contents are untouched by this block.

## Timing
- **`cr_wr`:** register updates on the same edge; the new START affects `tmr_tick` from the following cycle.
- **`tmr_tick`, `uf_pulse`, `tmr_load` (underflow):** 0-cycle latency from `src_evt`, so cascaded Timer B sees `ta_uf` in the same cycle.
- **`irq_set`:** registered; high exactly one cycle, the cycle after `uf`.
- **Force load:** `tmr_load` high exactly one cycle, 1 cycle after the `cr_wr` edge.
- **One-shot:** START reads 0 from the cycle after `uf`; no further ticks occur.
- **Pulse-mode PB:** width = cycles from the edge after `uf` until the edge after the next `phi2_en`, i.e. one phi2 period.
- **Throughput:** one tick per cycle maximum; back-to-back ticks with `tmr_zero` produce back-to-back `uf`.

## Test plan
- **Reset/readback:** reset; write 0x19 (START|RUNMODE|LOAD) -> `cr_rdata`=0x09 next cycle; `tmr_load` high one cycle; tick suppressed in that cycle.
- **Continuous underflow:** write 0x01, phi2 source, model latch=3 -> `uf_pulse` every 4 `phi2_en`; `irq_set` one cycle after each; START stays 1.
- **One-shot:** write 0x09, latch=2 -> one `uf`, reload to 2, START reads 0, no further ticks; `irq_set` once.
- **PB modes:**
  - Write 0x07 (toggle, PBON) -> `pb_out`=1 after START rise, then inverts per underflow; `pb_oe`=1.
  - Write 0x03 -> `pb_out` high exactly one phi2 period after each `uf`.
- **Cascade (`TIMER_B`=1):** write 0x41, pulse `ta_uf` 5 times with latch=4 -> one `uf_pulse` coincident with the 5th `ta_uf`. With 0x61 and `cnt_level`=0, no ticks.
- **Collisions:** a write of 0x00 in the `uf` cycle of continuous mode -> `uf`/`irq_set` still occur, then stop. A write of 0x01 in the one-shot `uf` cycle -> START remains 1. Assert `rst_n` mid-count -> all outputs 0 asynchronously.
